// File: rtl/task8_cordic_top.sv
// task8_cordic_top: multi-cycle IEEE-754 single-precision adder with start/done handshake.
// Define TASK8_TEST_PORTS_EN to expose the debug taps (captured operand A, stage enables).
module task8_cordic_top (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done
`ifdef TASK8_TEST_PORTS_EN
    ,
    output logic [31:0] test_result_dataa,
    output logic        test_enable_dataa,
    output logic        test_enable_add
`endif
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
    state_t state;

    logic [31:0] a_reg, b_reg, spec_val_r, spec_val_c, packed_c;
    logic [30:0] ka, kb, l_key, s_key;
    logic [23:0] l_man, s_man;
    logic [7:0]  diff, exp_r;
    logic [52:0] ext;
    logic [26:0] s_align, l_m_r, s_m_r, norm_m;
    logic [27:0] sum_r;
    logic [24:0] mr;
    logic [22:0] frac;
    logic [4:0]  lz;
    logic signed [9:0] norm_e, fin_e;
    logic swap, a_nan, b_nan, a_inf, b_inf, spec_c, round_up;
    logic l_sign_r, z_sign_r, sub_r, spec_r;

    function automatic logic [4:0] lzc(input logic [26:0] v);
        lzc = 5'd27;
        for (int i = 0; i < 27; i++)
            if (v[i]) lzc = 5'(26 - i);
    endfunction

    // Denormals flush to a zero magnitude key, so comparing keys orders |a| and |b|.
    assign ka      = (a_reg[30:23] == 8'd0) ? 31'd0 : a_reg[30:0];
    assign kb      = (b_reg[30:23] == 8'd0) ? 31'd0 : b_reg[30:0];
    assign swap    = kb > ka;
    assign l_key   = swap ? kb : ka;
    assign s_key   = swap ? ka : kb;
    assign l_man   = {|l_key[30:23], l_key[22:0]};
    assign s_man   = {|s_key[30:23], s_key[22:0]};
    assign diff    = l_key[30:23] - s_key[30:23];
    assign ext     = {s_man, 29'd0} >> diff;
    assign s_align = (diff >= 8'd26) ? {26'd0, |s_man} : {ext[52:27], ext[26] | (|ext[25:0])};

    assign a_nan      = (a_reg[30:23] == 8'hFF) && (a_reg[22:0] != 23'd0);
    assign b_nan      = (b_reg[30:23] == 8'hFF) && (b_reg[22:0] != 23'd0);
    assign a_inf      = (a_reg[30:23] == 8'hFF) && (a_reg[22:0] == 23'd0);
    assign b_inf      = (b_reg[30:23] == 8'hFF) && (b_reg[22:0] == 23'd0);
    assign spec_c     = a_nan | b_nan | a_inf | b_inf;
    assign spec_val_c = (a_nan | b_nan | (a_inf & b_inf & (a_reg[31] ^ b_reg[31]))) ? 32'h7FC00000 :
                        a_inf ? a_reg : b_reg;

    assign lz       = lzc(sum_r[26:0]);
    assign norm_m   = sum_r[27] ? {sum_r[27:2], sum_r[1] | sum_r[0]} : sum_r[26:0] << lz;
    assign norm_e   = sum_r[27] ? $signed({2'b0, exp_r}) + 10'sd1
                                : $signed({2'b0, exp_r}) - $signed({5'b0, lz});
    assign round_up = norm_m[2] & (norm_m[3] | norm_m[1] | norm_m[0]);
    assign mr       = {1'b0, norm_m[26:3]} + {24'd0, round_up};
    assign fin_e    = norm_e + $signed({9'd0, mr[24]});
    assign frac     = mr[24] ? mr[23:1] : mr[22:0];
    // An exactly-zero sum keeps -0 only when both inputs were negative zeros.
    assign packed_c = spec_r                ? spec_val_r :
                      (sum_r == 28'd0)      ? {z_sign_r, 31'd0} :
                      (fin_e >= 10'sd255)   ? {l_sign_r, 8'hFF, 23'd0} :
                      (fin_e <= 10'sd0)     ? {l_sign_r, 31'd0} :
                                              {l_sign_r, fin_e[7:0], frac};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            result     <= '0;
            done       <= 1'b0;
            l_sign_r   <= 1'b0;
            z_sign_r   <= 1'b0;
            sub_r      <= 1'b0;
            spec_r     <= 1'b0;
            spec_val_r <= '0;
            exp_r      <= '0;
            l_m_r      <= '0;
            s_m_r      <= '0;
            sum_r      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    a_reg <= dataa;
                    b_reg <= datab;
                    state <= ALIGN;
                end
                ALIGN: begin
                    l_sign_r   <= swap ? b_reg[31] : a_reg[31];
                    z_sign_r   <= a_reg[31] & b_reg[31];
                    sub_r      <= a_reg[31] ^ b_reg[31];
                    spec_r     <= spec_c;
                    spec_val_r <= spec_val_c;
                    exp_r      <= l_key[30:23];
                    l_m_r      <= {l_man, 3'b000};
                    s_m_r      <= s_align;
                    state      <= ADD;
                end
                ADD: begin
                    sum_r <= sub_r ? {1'b0, l_m_r} - {1'b0, s_m_r} : {1'b0, l_m_r} + {1'b0, s_m_r};
                    state <= NORM;
                end
                NORM: begin
                    result <= packed_c;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TASK8_TEST_PORTS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            test_result_dataa <= '0;
            test_enable_dataa <= 1'b0;
            test_enable_add   <= 1'b0;
        end else begin
            test_enable_dataa <= (state == IDLE) && start;
            test_enable_add   <= (state == ADD);
            if ((state == IDLE) && start) test_result_dataa <= dataa;
        end
    end
`endif
endmodule

// File: tb/tb_task8_cordic_top.sv
// tb_task8_cordic_top: randomized bench for task8_cordic_top against an exact-integer float-add model.
module tb_task8_cordic_top;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] dataa, datab, result;
    logic        done;
    int checks = 0;
    int errors = 0;
`ifdef TASK8_TEST_PORTS_EN
    logic [31:0] test_result_dataa;
    logic        test_enable_dataa, test_enable_add;
`endif

    task8_cordic_top dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .dataa(dataa),
        .datab(datab),
        .result(result),
        .done(done)
`ifdef TASK8_TEST_PORTS_EN
        ,
        .test_result_dataa(test_result_dataa),
        .test_enable_dataa(test_enable_dataa),
        .test_enable_add(test_enable_add)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [31:0] SPECIALS [12] = '{
        32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800001,
        32'h00000001, 32'h807FFFFF, 32'h3F800000, 32'h7F7FFFFF, 32'h00800000, 32'hFF7FFFFF
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Values are exact integers in units of 2^-149, so the sum is exact before one rounding step.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [279:0] va, vb, mag, keep, rem, half;
        logic s;
        int p, e;
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 32'h7FC00000;
        if (a[30:23] == 8'hFF && b[30:23] == 8'hFF) return (a[31] != b[31]) ? 32'h7FC00000 : a;
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return b;
        va = (a[30:23] == 0) ? '0 : 280'({1'b1, a[22:0]}) << (a[30:23] - 8'd1);
        vb = (b[30:23] == 0) ? '0 : 280'({1'b1, b[22:0]}) << (b[30:23] - 8'd1);
        if (a[31] == b[31]) begin mag = va + vb; s = a[31]; end
        else if (va >= vb) begin mag = va - vb; s = a[31]; end
        else begin mag = vb - va; s = b[31]; end
        if (mag == 0) return {a[31] & b[31], 31'd0};
        p = 0;
        for (int i = 0; i < 280; i++) if (mag[i]) p = i;
        e = p - 22;
        if (p >= 24) begin
            keep = mag >> (p - 23);
            rem  = mag & ((280'd1 << (p - 23)) - 280'd1);
            half = 280'd1 << (p - 24);
            if (rem > half || (rem == half && keep[0])) keep = keep + 280'd1;
        end else keep = mag << (23 - p);
        if (keep[24]) begin keep = keep >> 1; e++; end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), keep[22:0]};
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b);
        logic [4:0] dv, ev, av;
        logic [31:0] exp, r3;
        exp = ref_add(a, b);
        ev = '0;
        av = '0;
        r3 = '0;
        @(negedge clk);
        dataa = a; datab = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dataa = $urandom; datab = $urandom;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            dv[i] = done;
            if (i == 3) r3 = result;
`ifdef TASK8_TEST_PORTS_EN
            ev[i] = test_enable_dataa;
            av[i] = test_enable_add;
`endif
        end
        check("sum", r3, exp);
        check("hold", result, exp);
        check("done_timing", {27'd0, dv}, 32'h08);
`ifdef TASK8_TEST_PORTS_EN
        check("en_dataa", {27'd0, ev}, 32'h01);
        check("en_add", {27'd0, av}, 32'h04);
        check("cap_dataa", test_result_dataa, a);
`endif
    endtask

    initial begin
        logic [10:0] hv;
        logic [31:0] r1, r2, a, b;
        logic        saw;
        reset_n = 1'b0; start = 1'b0; dataa = '0; datab = '0;
        r1 = '0; r2 = '0;
        #12;
        check("rst_result", result, 32'h0);
        check("rst_done", {31'd0, done}, 32'h0);
`ifdef TASK8_TEST_PORTS_EN
        check("rst_taps", {29'd0, test_enable_dataa, test_enable_add, |test_result_dataa}, 32'h0);
`endif
        @(negedge clk); reset_n = 1'b1;

        do_op(32'h437F0000, 32'h43000000);
        do_op(32'h3F800000, 32'hBF800000);
        do_op(32'h80000000, 32'h80000000);
        do_op(32'h3F800000, 32'h33800000);
        do_op(32'h3F800001, 32'h33800000);
        do_op(32'h7F800000, 32'hFF800000);
        do_op(32'h7F7FFFFF, 32'h7F7FFFFF);
        do_op(32'h7FC00001, 32'h3F800000);

        // start held for six edges: accepted at the first edge and again once IDLE returns
        @(negedge clk);
        dataa = 32'h3F800000; datab = 32'h40000000; start = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            if (i == 0) dataa = 32'h40400000;
            if (i == 5) start = 1'b0;
            hv[i] = done;
            if (i == 3) r1 = result;
            if (i == 8) r2 = result;
        end
        check("held_done", {21'd0, hv}, 32'h108);
        check("held_first", r1, ref_add(32'h3F800000, 32'h40000000));
        check("held_second", r2, ref_add(32'h40400000, 32'h40000000));

        // reset asserted during the ADD cycle
        @(negedge clk);
        dataa = 32'h437F0000; datab = 32'h43000000; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("abort_result", result, 32'h0);
        check("abort_done", {31'd0, done}, 32'h0);
`ifdef TASK8_TEST_PORTS_EN
        check("abort_taps", {29'd0, test_enable_dataa, test_enable_add, |test_result_dataa}, 32'h0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        saw = 1'b0;
        repeat (6) begin @(posedge clk); #1; saw = saw | done; end
        check("abort_no_done", {31'd0, saw}, 32'h0);
        do_op(32'h437F0000, 32'h43000000);

        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = $urandom;
                1: b = a ^ 32'h80000000 ^ 32'($urandom_range(0, 15));
                2: b = {1'($urandom), a[30:23] + 8'($urandom_range(0, 3)) - 8'd1, 23'($urandom)};
                3: begin a = SPECIALS[$urandom_range(0, 11)]; b = $urandom_range(0, 1) ? SPECIALS[$urandom_range(0, 11)] : $urandom; end
                4: begin a = {1'($urandom), 8'($urandom_range(1, 3)), 23'($urandom)}; b = {1'($urandom), 8'($urandom_range(1, 3)), 23'($urandom)}; end
                default: begin a = {1'($urandom), 8'($urandom_range(250, 254)), 23'($urandom)}; b = {a[31], 8'($urandom_range(250, 254)), 23'($urandom)}; end
            endcase
            do_op(a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
